// File: rtl/ddfs_ctrl.sv
// Push-button front end producing the DDFS control word (mode, mirror, fw, divider range).
// Define DDFS_CTRL_AUTOREPEAT_EN to add hold-to-repeat on btn_up/btn_down.
module ddfs_ctrl #(
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned REP_DELAY  = 25000000,
   parameter int unsigned REP_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_mode,
   input  logic       btn_range,
   output logic       sin,
   output logic       triang,
   output logic       mirror_x,
   output logic       mirror_y,
   output logic [6:0] fw,
   output logic [2:0] freq_cntrl,
   output logic       cfg_valid
);

   localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CMax = CW'(DEB_CYCLES - 1);

   typedef enum logic [2:0] {
      StSq, StTri, StSin, StSinFull, StTriFull, StSqFull
   } mode_e;

   // Bit order everywhere: {range, mode, down, up}
   logic [3:0]         btn_raw;
   logic [3:0]         sync_q, s_q, d_q, d_dly_q, p_q;
   logic [3:0][CW-1:0] cnt_q;
   logic               step_up, step_down;
   mode_e              mode_q, mode_nxt;
   logic [13:0]        cfg_bundle, cfg_prev_q;

   assign btn_raw = {btn_range, btn_mode, btn_down, btn_up};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         s_q     <= '0;
         d_q     <= '0;
         d_dly_q <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= btn_raw;
         s_q     <= sync_q;
         d_dly_q <= d_q;
         p_q     <= d_q & ~d_dly_q;
         for (int i = 0; i < 4; i++) begin
            if (s_q[i] == d_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CMax) begin
               d_q[i]   <= s_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef DDFS_CTRL_AUTOREPEAT_EN
   localparam int unsigned RMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int unsigned RW   = $clog2(RMax + 1);

   logic [RW-1:0] hold_q;
   logic          phase_q, rep_up_q, rep_down_q, holding;

   // Exactly one of up/down held; holding both suppresses repeat.
   assign holding = d_q[0] ^ d_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q     <= '0;
         phase_q    <= 1'b0;
         rep_up_q   <= 1'b0;
         rep_down_q <= 1'b0;
      end else begin
         rep_up_q   <= 1'b0;
         rep_down_q <= 1'b0;
         if (!holding) begin
            hold_q  <= '0;
            phase_q <= 1'b0;
         end else if (hold_q == (phase_q ? RW'(REP_PERIOD) : RW'(REP_DELAY))) begin
            hold_q     <= RW'(1);
            phase_q    <= 1'b1;
            rep_up_q   <= d_q[0];
            rep_down_q <= d_q[1];
         end else begin
            hold_q <= hold_q + 1'b1;
         end
      end
   end

   assign step_up   = p_q[0] | rep_up_q;
   assign step_down = p_q[1] | rep_down_q;
`else
   assign step_up   = p_q[0];
   assign step_down = p_q[1];
`endif

   always_comb begin
      mode_nxt = StSq;
      case (mode_q)
         StSq:      mode_nxt = p_q[2] ? StTri     : StSq;
         StTri:     mode_nxt = p_q[2] ? StSin     : StTri;
         StSin:     mode_nxt = p_q[2] ? StSinFull : StSin;
         StSinFull: mode_nxt = p_q[2] ? StTriFull : StSinFull;
         StTriFull: mode_nxt = p_q[2] ? StSqFull  : StTriFull;
         StSqFull:  mode_nxt = p_q[2] ? StSq      : StSqFull;
         default:   mode_nxt = StSq;
      endcase
   end

   function automatic logic [3:0] mode_bits(input mode_e m);
      case (m)
         StTri:     mode_bits = 4'b0100;
         StSin:     mode_bits = 4'b1000;
         StSinFull: mode_bits = 4'b1011;
         StTriFull: mode_bits = 4'b0111;
         StSqFull:  mode_bits = 4'b0010;
         default:   mode_bits = 4'b0000;
      endcase
   endfunction

   assign cfg_bundle = {sin, triang, mirror_x, mirror_y, fw, freq_cntrl};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q                             <= StSq;
         {sin, triang, mirror_x, mirror_y}  <= 4'b0000;
         fw                                 <= 7'd0;
         freq_cntrl                         <= 3'd0;
         cfg_prev_q                         <= '0;
         cfg_valid                          <= 1'b0;
      end else begin
         mode_q                            <= mode_nxt;
         {sin, triang, mirror_x, mirror_y} <= mode_bits(mode_nxt);
         if (step_up && !step_down && fw != 7'd127) begin
            fw <= fw + 7'd1;
         end else if (step_down && !step_up && fw != 7'd0) begin
            fw <= fw - 7'd1;
         end
         if (p_q[3]) begin
            freq_cntrl <= freq_cntrl + 3'd1;
         end
         // Pulse only when the registered control word really moved.
         cfg_prev_q <= cfg_bundle;
         cfg_valid  <= (cfg_bundle != cfg_prev_q);
      end
   end

endmodule

// File: tb/tb_ddfs_ctrl.sv
// Directed bench for ddfs_ctrl with DEB_CYCLES=4 (auto-repeat check only when the macro is set).
module tb_ddfs_ctrl;

   logic       clk, rst;
   logic       btn_up, btn_down, btn_mode, btn_range;
   logic       sin, triang, mirror_x, mirror_y, cfg_valid;
   logic [6:0] fw;
   logic [2:0] freq_cntrl;
   logic [3:0] mode_out;

   int n_vec = 0;
   int n_err = 0;
   int cfg_total = 0;

   ddfs_ctrl #(
      .DEB_CYCLES(4),
      .REP_DELAY (10),
      .REP_PERIOD(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_mode  (btn_mode),
      .btn_range (btn_range),
      .sin       (sin),
      .triang    (triang),
      .mirror_x  (mirror_x),
      .mirror_y  (mirror_y),
      .fw        (fw),
      .freq_cntrl(freq_cntrl),
      .cfg_valid (cfg_valid)
   );

   assign mode_out = {sin, triang, mirror_x, mirror_y};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (cfg_valid) cfg_total <= cfg_total + 1;

   typedef struct {
      logic [3:0] btn;   // {range, mode, down, up}
      logic [6:0] fw;
      logic [2:0] fc;
      logic [3:0] mo;
      int         cfg;
   } vec_t;

   vec_t vecs [22];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
   endtask

   task automatic press(input logic [3:0] b, output int pulses);
      int c0;
      @(negedge clk);
      c0 = cfg_total;
      {btn_range, btn_mode, btn_down, btn_up} = b;
      cycles(10);
      {btn_range, btn_mode, btn_down, btn_up} = 4'b0000;
      cycles(12);
      pulses = cfg_total - c0;
   endtask

   initial begin
      int p;
      int tot;
      rst = 1'b1;
      {btn_range, btn_mode, btn_down, btn_up} = 4'b0000;

      vecs[0]  = '{4'b0010, 7'd0, 3'd0, 4'b0000, 0};
      vecs[1]  = '{4'b0001, 7'd1, 3'd0, 4'b0000, 1};
      vecs[2]  = '{4'b0011, 7'd1, 3'd0, 4'b0000, 0};
      vecs[3]  = '{4'b1001, 7'd2, 3'd1, 4'b0000, 1};
      vecs[4]  = '{4'b0100, 7'd2, 3'd1, 4'b0100, 1};
      vecs[5]  = '{4'b0100, 7'd2, 3'd1, 4'b1000, 1};
      vecs[6]  = '{4'b0100, 7'd2, 3'd1, 4'b1011, 1};
      vecs[7]  = '{4'b0100, 7'd2, 3'd1, 4'b0111, 1};
      vecs[8]  = '{4'b0100, 7'd2, 3'd1, 4'b0010, 1};
      vecs[9]  = '{4'b0100, 7'd2, 3'd1, 4'b0000, 1};
      vecs[10] = '{4'b0100, 7'd2, 3'd1, 4'b0100, 1};
      vecs[11] = '{4'b1000, 7'd2, 3'd2, 4'b0100, 1};
      vecs[12] = '{4'b1000, 7'd2, 3'd3, 4'b0100, 1};
      vecs[13] = '{4'b1000, 7'd2, 3'd4, 4'b0100, 1};
      vecs[14] = '{4'b1000, 7'd2, 3'd5, 4'b0100, 1};
      vecs[15] = '{4'b1000, 7'd2, 3'd6, 4'b0100, 1};
      vecs[16] = '{4'b1000, 7'd2, 3'd7, 4'b0100, 1};
      vecs[17] = '{4'b1000, 7'd2, 3'd0, 4'b0100, 1};
      vecs[18] = '{4'b1000, 7'd2, 3'd1, 4'b0100, 1};
      vecs[19] = '{4'b0110, 7'd1, 3'd1, 4'b1000, 1};
      vecs[20] = '{4'b0010, 7'd0, 3'd1, 4'b1000, 1};
      vecs[21] = '{4'b0010, 7'd0, 3'd1, 4'b1000, 0};

      // Reset values
      cycles(3);
      chk("reset_fw", fw, 0);
      chk("reset_fc", freq_cntrl, 0);
      chk("reset_mode", mode_out, 0);
      chk("reset_cfg", cfg_valid, 0);
      rst = 1'b0;

      // Exact latency: raw edge between edge 0 and edge 1, fw moves at edge 8
      @(negedge clk);
      btn_up = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("lat_fw_k%0d", k), fw, (k >= 8) ? 1 : 0);
         chk($sformatf("lat_cfg_k%0d", k), cfg_valid, (k == 9) ? 1 : 0);
      end
      btn_up = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         chk($sformatf("rel_fw_k%0d", k), fw, 1);
         chk($sformatf("rel_cfg_k%0d", k), cfg_valid, 0);
      end

      // Bounce shorter than the debounce window, then a stable press
      do_reset();
      tot = cfg_total;
      for (int k = 0; k < 8; k++) begin
         btn_up = ~btn_up;
         cycles(2);
      end
      btn_up = 1'b1;
      cycles(15);
      btn_up = 1'b0;
      cycles(15);
      chk("bounce_fw", fw, 1);
      chk("bounce_cfg", cfg_total - tot, 1);

      // Table of single presses
      do_reset();
      for (int i = 0; i < 22; i++) begin
         press(vecs[i].btn, p);
         chk($sformatf("vec%0d_fw", i), fw, vecs[i].fw);
         chk($sformatf("vec%0d_fc", i), freq_cntrl, vecs[i].fc);
         chk($sformatf("vec%0d_mode", i), mode_out, vecs[i].mo);
         chk($sformatf("vec%0d_cfg", i), p, vecs[i].cfg);
      end

      // Saturation at the top
      tot = 0;
      for (int i = 0; i < 128; i++) begin
         press(4'b0001, p);
         tot += p;
      end
      chk("sat_fw", fw, 127);
      chk("sat_cfg_total", tot, 127);
      press(4'b0001, p);
      chk("sat129_fw", fw, 127);
      chk("sat129_cfg", p, 0);

      // Asynchronous reset in the middle of a debounce, button held through release
      do_reset();
      for (int i = 0; i < 5; i++) press(4'b0001, p);
      press(4'b0100, p);
      chk("pre_rst_fw", fw, 5);
      chk("pre_rst_mode", mode_out, 4'b0100);
      @(negedge clk);
      btn_up = 1'b1;
      cycles(3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_fw", fw, 0);
      chk("async_rst_mode", mode_out, 0);
      chk("async_rst_fc", freq_cntrl, 0);
      chk("async_rst_cfg", cfg_valid, 0);
      cycles(2);
      rst = 1'b0;
      cycles(7);
      chk("rst_held_fw_k7", fw, 0);
      cycles(1);
      chk("rst_held_fw_k8", fw, 1);
      btn_up = 1'b0;
      cycles(15);

`ifdef DDFS_CTRL_AUTOREPEAT_EN
      // Repeat steps 10, 13 and 16 cycles after the first increment at edge 8
      do_reset();
      @(negedge clk);
      btn_up = 1'b1;
      for (int k = 1; k <= 26; k++) begin
         int e;
         @(negedge clk);
         e = (k < 8) ? 0 : (k < 18) ? 1 : (k < 21) ? 2 : (k < 24) ? 3 : 4;
         chk($sformatf("rep_fw_k%0d", k), fw, e);
      end
      btn_up = 1'b0;
      cycles(15);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
